// File: rtl/fp_mul_pkg.sv
// Shared floating-point multiplier types, constants and helpers.
package fp_mul_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [FP_W-1:0] FP_INF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_operand_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight multiply.
module fp_tag_fifo
  import fp_mul_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters.
// Define FP_MUL_ARB_PERF_EN to add perf_issue/perf_ovf/perf_stall counters.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  output logic [N_REQ-1:0]      req_rdy,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  output logic [N_REQ-1:0]      rsp_vld,
  output logic [FP_W-1:0]       rsp_res,
  output logic                  rsp_ovf,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FP_W-1:0]       mul_a,
  output logic [FP_W-1:0]       mul_b,
  output logic                  mul_vld,
  input  logic [FP_W-1:0]       mul_res,
  input  logic                  mul_res_vld,
  input  logic                  mul_ovf,
  output logic                  busy,
  output logic                  err_unexp
`ifdef FP_MUL_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issue,
  output logic [15:0]           perf_ovf,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned CNT_W = clog2(MAX_OUT) + 1;

  fp_operand_t      ops [N_REQ];
  fp_operand_t      mul_op_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  start_q, start_d;
  logic [ID_W-1:0]  scan_idx, win_id, tag;
  logic             issue_ok, accept, pop;
  logic             fifo_full, fifo_empty;
  logic             mul_vld_q, rsp_ovf_q, err_q;
  logic [N_REQ-1:0] rsp_vld_q;
  logic [FP_W-1:0]  rsp_res_q;
  logic [ID_W-1:0]  rsp_id_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_ops
    assign ops[g] = '{a: req_a[g*FP_W +: FP_W], b: req_b[g*FP_W +: FP_W]};
  end

  // Credits come from the registered count, so a slot freed this cycle is reused next cycle.
  assign issue_ok = rst && (cnt_q < CNT_W'(MAX_OUT)) && !fifo_full;
  assign pop      = mul_res_vld && !fifo_empty;

  // Search starts one past the last winner; start_q resets to requester 0.
  always_comb begin
    req_rdy  = '0;
    win_id   = '0;
    scan_idx = '0;
    accept   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((32'(start_q) + k) % N_REQ);
      if (!accept && issue_ok && req_vld[scan_idx]) begin
        accept = 1'b1;
        win_id = scan_idx;
      end
    end
    if (accept) req_rdy[win_id] = 1'b1;
  end

  always_comb begin
    start_d = accept ? ID_W'((32'(win_id) + 32'd1) % N_REQ) : start_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      start_q   <= '0;
      mul_vld_q <= 1'b0;
      mul_op_q  <= '0;
      rsp_vld_q <= '0;
      rsp_res_q <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_id_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      mul_vld_q <= accept;
      if (accept) mul_op_q <= ops[win_id];
      rsp_vld_q <= pop ? (N_REQ'(1) << tag) : '0;
      if (pop) begin
        rsp_res_q <= mul_res;
        rsp_ovf_q <= mul_ovf;
        rsp_id_q  <= tag;
      end
      err_q     <= err_q | (mul_res_vld & fifo_empty);
    end
  end

  fp_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (win_id),
    .dout_o  (tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mul_vld   = mul_vld_q;
  assign mul_a     = mul_op_q.a;
  assign mul_b     = mul_op_q.b;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;
  assign err_unexp = err_q;
  assign busy      = (cnt_q != '0) || (|rsp_vld_q);

`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;
  logic [15:0] perf_ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_q <= '0;
      perf_ovf_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_q + 32'(accept);
      perf_ovf_q   <= perf_ovf_q + 16'(pop && mul_ovf);
      perf_stall_q <= perf_stall_q + 32'((|req_vld) && !issue_ok);
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_ovf   = perf_ovf_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a behavioural multiplier model.
module tb_fp_mul_arbiter;
  import fp_mul_pkg::*;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_REQ-1:0]      req_vld = '0;
  logic [N_REQ-1:0]      req_rdy;
  logic [N_REQ*FP_W-1:0] req_a, req_b;
  logic [N_REQ-1:0]      rsp_vld;
  logic [FP_W-1:0]       rsp_res;
  logic                  rsp_ovf;
  logic [ID_W-1:0]       rsp_id;
  logic [FP_W-1:0]       mul_a, mul_b;
  logic                  mul_vld;
  logic [FP_W-1:0]       mul_res = '0;
  logic                  mul_res_vld = 1'b0;
  logic                  mul_ovf = 1'b0;
  logic                  busy, err_unexp;
`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0]           perf_issue, perf_stall;
  logic [15:0]           perf_ovf;
`endif

  logic [31:0] op_a [N_REQ];
  logic [31:0] op_b [N_REQ];
  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  fp_mul_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .rsp_vld(rsp_vld), .rsp_res(rsp_res),
    .rsp_ovf(rsp_ovf), .rsp_id(rsp_id), .mul_a(mul_a), .mul_b(mul_b),
    .mul_vld(mul_vld), .mul_res(mul_res), .mul_res_vld(mul_res_vld),
    .mul_ovf(mul_ovf), .busy(busy), .err_unexp(err_unexp)
`ifdef FP_MUL_ARB_PERF_EN
    , .perf_issue(perf_issue), .perf_ovf(perf_ovf), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { logic [ID_W-1:0] id; logic [31:0] res; logic ovf; } exp_t;
  typedef struct { logic [31:0] res; logic ovf; int due; } pend_t;

  exp_t       exp_q  [$];
  pend_t      pend_q [$];
  int         acc_q  [$];
  bit         stall       = 1'b0;
  bit         inject      = 1'b0;
  bit         hold_vld    = 1'b0;
  int         release_cnt = 0;
  logic [3:0] acc_last    = '0;

  // Truncating single-precision multiply; {ovf, result}.
  function automatic logic [32:0] fp_mul_model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), m};
  endfunction

  // Multiplier model, accept tracker and response scoreboard.
  always @(negedge clk) begin : mon
    logic [32:0] r;
    exp_t        e;
    pend_t       p;
    logic [3:0]  acc;
    cyc++;
    if (!rst) begin
      pend_q.delete();
      exp_q.delete();
      mul_res_vld = 1'b0;
      acc_last    = '0;
    end else begin
      if (rsp_vld != '0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: rsp_vld=%b with nothing expected", rsp_vld);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rsp_vld !== (4'b0001 << e.id)) begin
            failures++; $display("FAIL sb_rsp_vld: got %b want %b", rsp_vld, 4'b0001 << e.id);
          end
          checks++;
          if (rsp_id !== e.id) begin
            failures++; $display("FAIL sb_rsp_id: got %0d want %0d", rsp_id, e.id);
          end
          checks++;
          if (rsp_res !== e.res) begin
            failures++; $display("FAIL sb_rsp_res: got %h want %h", rsp_res, e.res);
          end
          checks++;
          if (rsp_ovf !== e.ovf) begin
            failures++; $display("FAIL sb_rsp_ovf: got %b want %b", rsp_ovf, e.ovf);
          end
        end
      end
      if (mul_vld === 1'b1) begin
        r = fp_mul_model(mul_a, mul_b);
        pend_q.push_back('{res: r[31:0], ovf: r[32], due: cyc + 2});
      end
      mul_res_vld = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && (!stall || release_cnt > 0)) begin
        p = pend_q.pop_front();
        mul_res     = p.res;
        mul_ovf     = p.ovf;
        mul_res_vld = 1'b1;
        if (stall) release_cnt--;
      end else if (inject) begin
        mul_res     = 32'h3F80_0000;
        mul_ovf     = 1'b0;
        mul_res_vld = 1'b1;
        inject      = 1'b0;
      end
      acc      = req_vld & req_rdy;
      acc_last = acc;
      for (int i = 0; i < 4; i++) begin
        if (acc[ID_W'(i)]) begin
          r = fp_mul_model(op_a[ID_W'(i)], op_b[ID_W'(i)]);
          exp_q.push_back('{id: ID_W'(i), res: r[31:0], ovf: r[32]});
          acc_q.push_back(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (!hold_vld) req_vld = req_vld & ~acc_last;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_vld = '0;
    hold_vld = 1'b0;
    stall = 1'b0;
    release_cnt = 0;
    inject = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    acc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_vld = '0;
    #1;
    checks++; if (req_rdy !== 4'b0)  begin failures++; $display("FAIL reset_req_rdy: got %b want 0", req_rdy); end
    checks++; if (rsp_vld !== 4'b0)  begin failures++; $display("FAIL reset_rsp_vld: got %b want 0", rsp_vld); end
    checks++; if (mul_vld !== 1'b0)  begin failures++; $display("FAIL reset_mul_vld: got %b want 0", mul_vld); end
    checks++; if (mul_a !== 32'h0)   begin failures++; $display("FAIL reset_mul_a: got %h want 0", mul_a); end
    checks++; if (mul_b !== 32'h0)   begin failures++; $display("FAIL reset_mul_b: got %h want 0", mul_b); end
    checks++; if (rsp_res !== 32'h0) begin failures++; $display("FAIL reset_rsp_res: got %h want 0", rsp_res); end
    checks++; if (rsp_ovf !== 1'b0)  begin failures++; $display("FAIL reset_rsp_ovf: got %b want 0", rsp_ovf); end
    checks++; if (rsp_id !== 2'd0)   begin failures++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_unexp); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_lone_request();
    int n;
    apply_reset();
    op_a[0] = 32'h4060_0000;
    op_b[0] = 32'h4000_0000;
    req_vld = 4'b0001;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL lone_rdy: got %b want 0001", req_rdy); end
    step();
    @(negedge clk);
    checks++; if (mul_vld !== 1'b1) begin failures++; $display("FAIL lone_mul_vld: got %b want 1", mul_vld); end
    checks++; if (mul_a !== 32'h4060_0000) begin failures++; $display("FAIL lone_mul_a: got %h want 40600000", mul_a); end
    checks++; if (mul_b !== 32'h4000_0000) begin failures++; $display("FAIL lone_mul_b: got %h want 40000000", mul_b); end
    step();
    @(negedge clk);
    checks++; if (mul_vld !== 1'b0) begin failures++; $display("FAIL lone_mul_vld_drop: got %b want 0", mul_vld); end
    n = 0;
    while (rsp_vld === 4'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rsp_vld !== 4'b0001) begin failures++; $display("FAIL lone_rsp_vld: got %b want 0001", rsp_vld); end
    checks++; if (rsp_res !== 32'h40E0_0000) begin failures++; $display("FAIL lone_rsp_res: got %h want 40e00000", rsp_res); end
    checks++; if (rsp_ovf !== 1'b0) begin failures++; $display("FAIL lone_rsp_ovf: got %b want 0", rsp_ovf); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL lone_rsp_id: got %0d want 0", rsp_id); end
    n = 0;
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lone_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int          exp_order [6] = '{0, 1, 2, 3, 0, 1};
    bit          seen2;
    logic [31:0] res2;
    logic [1:0]  id2;
    apply_reset();
    op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000;
    op_a[1] = 32'h4060_0000; op_b[1] = 32'h4000_0000;
    op_a[2] = 32'hBFC0_0000; op_b[2] = 32'h4080_0000;
    op_a[3] = 32'h4000_0000; op_b[3] = 32'h4000_0000;
    hold_vld = 1'b1;
    req_vld = 4'b1111;
    seen2 = 1'b0;
    res2 = '0;
    id2 = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (rsp_vld[2] === 1'b1) begin seen2 = 1'b1; res2 = rsp_res; id2 = rsp_id; end
      if (c < 6) begin
        checks++;
        if ($countones(req_rdy) != 1) begin failures++; $display("FAIL rr_onehot c%0d: got %b want one-hot", c, req_rdy); end
      end
      step();
      if (c == 5) begin req_vld = '0; hold_vld = 1'b0; end
    end
    checks++; if (acc_q.size() != 6) begin failures++; $display("FAIL rr_accepts: got %0d want 6", acc_q.size()); end
    for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] != exp_order[k]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, acc_q[k], exp_order[k]); end
    end
    checks++; if (!seen2) begin failures++; $display("FAIL rr_rsp2_seen: got 0 want 1"); end
    checks++; if (res2 !== 32'hC0C0_0000) begin failures++; $display("FAIL rr_rsp2_res: got %h want c0c00000", res2); end
    checks++; if (id2 !== 2'd2) begin failures++; $display("FAIL rr_rsp2_id: got %0d want 2", id2); end
  endtask

  task automatic test_credit_limit();
    int n;
    apply_reset();
    stall = 1'b1;
    hold_vld = 1'b1;
    req_vld = 4'b1111;
    repeat (12) step();
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0) begin failures++; $display("FAIL credit_full_rdy: got %b want 0", req_rdy); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL credit_busy: got %b want 1", busy); end
    checks++; if (acc_q.size() != 8) begin failures++; $display("FAIL credit_accepts: got %0d want 8", acc_q.size()); end
    step();
    release_cnt = 1;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0) begin failures++; $display("FAIL credit_same_cycle: got %b want 0", req_rdy); end
    step();
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL credit_reissue: got %b want 0001", req_rdy); end
    step();
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0) begin failures++; $display("FAIL credit_refull: got %b want 0", req_rdy); end
    checks++; if (acc_q.size() != 9) begin failures++; $display("FAIL credit_one_more: got %0d want 9", acc_q.size()); end
    req_vld = '0;
    hold_vld = 1'b0;
    stall = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL credit_drain: busy got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int n;
    apply_reset();
    op_a[3] = 32'h7F00_0000;
    op_b[3] = 32'h7F00_0000;
    req_vld = 4'b1000;
    step();
    n = 0;
    @(negedge clk);
    while (rsp_vld === 4'b0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (rsp_vld !== 4'b1000) begin failures++; $display("FAIL ovf_rsp_vld: got %b want 1000", rsp_vld); end
    checks++; if (rsp_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", rsp_ovf); end
    checks++; if (rsp_res !== FP_INF) begin failures++; $display("FAIL ovf_res: got %h want %h", rsp_res, FP_INF); end
    checks++; if (rsp_id !== 2'd3) begin failures++; $display("FAIL ovf_id: got %0d want 3", rsp_id); end
`ifdef FP_MUL_ARB_PERF_EN
    checks++; if (perf_ovf !== 16'd1) begin failures++; $display("FAIL perf_ovf: got %0d want 1", perf_ovf); end
    checks++; if (perf_issue !== 32'd1) begin failures++; $display("FAIL perf_issue: got %0d want 1", perf_issue); end
`endif
  endtask

  task automatic test_unexpected();
    apply_reset();
    inject = 1'b1;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      checks++; if (rsp_vld !== 4'b0) begin failures++; $display("FAIL unexp_rsp: got %b want 0", rsp_vld); end
      checks++; if (err_unexp !== 1'b1) begin failures++; $display("FAIL unexp_err: got %b want 1", err_unexp); end
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL unexp_err_clear: got %b want 0", err_unexp); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int n;
    apply_reset();
    stall = 1'b1;
    hold_vld = 1'b1;
    req_vld = 4'b1111;
    repeat (5) step();
    req_vld = '0;
    hold_vld = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", busy); end
    checks++; if (acc_q.size() != 5) begin failures++; $display("FAIL mid_accepts: got %0d want 5", acc_q.size()); end
    req_vld = 4'b1111;
    #2 rst = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0) begin failures++; $display("FAIL mid_rdy: got %b want 0", req_rdy); end
    checks++; if (mul_vld !== 1'b0) begin failures++; $display("FAIL mid_mul_vld: got %b want 0", mul_vld); end
    checks++; if (mul_a !== 32'h0) begin failures++; $display("FAIL mid_mul_a: got %h want 0", mul_a); end
    checks++; if (rsp_vld !== 4'b0) begin failures++; $display("FAIL mid_rsp_vld: got %b want 0", rsp_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_clear: got %b want 0", busy); end
    stall = 1'b0;
    req_vld = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    acc_q.delete();
    req_vld = 4'b1111;
    @(negedge clk);
    checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL mid_restart: got %b want 0001", req_rdy); end
    step();
    req_vld = '0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_drain: busy got %b want 0", busy); end
    checks++; if (err_unexp !== 1'b0) begin failures++; $display("FAIL mid_no_err: got %b want 0", err_unexp); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      op_a[ID_W'(i)] = '0;
      op_b[ID_W'(i)] = '0;
    end
    #2;
    test_reset();
    test_lone_request();
    test_round_robin();
    test_credit_limit();
    test_overflow();
    test_unexpected();
    test_reset_midflight();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
